dram_port_arbiter: RTL and testbench

- Shares the single data port of the DRAM block, which has 1-cycle read latency, between two requesters.
  - Port 0: CPU load/store unit, high priority.
  - Port 1: DMA/debug master, low priority with anti-starvation.
- Sits between the requesters and the DRAM EN/ADDR/WE/BE/WDATA/IS_CAP/RDATA interface.
- Issues at most one memory access per cycle and routes read data and write completions back to the owning requester.

---
 rtl/dram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_dram_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// Two-port arbiter for the single-port DRAM data interface: port 0 (CPU) has
// priority, port 1 (DMA/debug) is force-granted after STARVE_LIMIT denials.
module dram_port_arbiter #(
   parameter int DATA_WIDTH   = 33,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rstn,

   input  logic                  p0_req,
   input  logic [31:0]           p0_addr,
   input  logic                  p0_is_cap,
   input  logic                  p0_we,
   input  logic [3:0]            p0_be,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_gnt,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,

   input  logic                  p1_req,
   input  logic [31:0]           p1_addr,
   input  logic                  p1_is_cap,
   input  logic                  p1_we,
   input  logic [3:0]            p1_be,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_gnt,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata,

   output logic                  mem_en,
   output logic [31:0]           mem_addr,
   output logic                  mem_is_cap,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [0:0] ST_NORMAL = 1'b0;
   localparam logic [0:0] ST_FORCE1 = 1'b1;
   localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

   logic [0:0] state_q, state_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       resp_valid_q, resp_owner_q, resp_we_q;
   logic       gnt0, gnt1;

   // NOTE: every signal gets a default at the top of the block so no path
   // through the case/if tree leaves it unassigned and infers a latch.
   always_comb begin
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      state_d      = ST_NORMAL;
      starve_cnt_d = '0;
      // Grants are gated by rstn so mem_en drops the moment reset asserts.
      if (rstn) begin
         case (state_q)
            ST_FORCE1: begin
               if (p1_req) gnt1 = 1'b1;
               else        gnt0 = p0_req;
            end
            default: begin
               gnt0 = p0_req;
               gnt1 = ~p0_req & p1_req;
               if (p1_req && !gnt1) begin
                  starve_cnt_d = starve_cnt_q + 4'd1;
                  if (starve_cnt_d == LIMIT) state_d = ST_FORCE1;
               end
            end
         endcase
      end
   end

   always_comb begin
      mem_en     = gnt0 | gnt1;
      mem_addr   = '0;
      mem_is_cap = 1'b0;
      mem_we     = 1'b0;
      mem_be     = '0;
      mem_wdata  = '0;
      if (gnt0) begin
         mem_addr   = p0_addr;
         mem_is_cap = p0_is_cap;
         mem_we     = p0_we;
         mem_be     = p0_be;
         mem_wdata  = p0_wdata;
      end else if (gnt1) begin
         mem_addr   = p1_addr;
         mem_is_cap = p1_is_cap;
         mem_we     = p1_we;
         mem_be     = p1_be;
         mem_wdata  = p1_wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_NORMAL;
         starve_cnt_q <= '0;
         resp_valid_q <= 1'b0;
         resp_owner_q <= 1'b0;
         resp_we_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         resp_valid_q <= mem_en;
         if (mem_en) begin
            resp_owner_q <= gnt1;
            resp_we_q    <= mem_we;
         end
      end
   end

   assign p0_gnt    = gnt0;
   assign p1_gnt    = gnt1;
   assign p0_rvalid = resp_valid_q & ~resp_owner_q;
   assign p1_rvalid = resp_valid_q &  resp_owner_q;
   // Write completions return zero data to the owner.
   assign p0_rdata  = (p0_rvalid & ~resp_we_q) ? mem_rdata : '0;
   assign p1_rdata  = (p1_rvalid & ~resp_we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed scenarios then held-until-granted random
// traffic, checked against a streak-count model for STARVE_LIMIT 4 and 1.
module tb_dram_port_arbiter;

   localparam int DW = 65;

   logic          clk = 1'b0;
   logic          rstn;
   logic          p0_req, p0_is_cap, p0_we, p1_req, p1_is_cap, p1_we;
   logic [31:0]   p0_addr, p1_addr;
   logic [3:0]    p0_be, p1_be;
   logic [DW-1:0] p0_wdata, p1_wdata, mem_rdata;

   logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata;
   logic          mem_en, mem_is_cap, mem_we;
   logic [31:0]   mem_addr;
   logic [3:0]    mem_be;

   logic          b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid;
   logic [DW-1:0] b_p0_rdata, b_p1_rdata, b_mem_wdata;
   logic          b_mem_en, b_mem_is_cap, b_mem_we;
   logic [31:0]   b_mem_addr;
   logic [3:0]    b_mem_be;

   always #5 clk = ~clk;

   dram_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rstn(rstn),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_is_cap(p0_is_cap), .p0_we(p0_we),
      .p0_be(p0_be), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
      .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_is_cap(p1_is_cap), .p1_we(p1_we),
      .p1_be(p1_be), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
      .p1_rdata(p1_rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_is_cap(mem_is_cap), .mem_we(mem_we),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   dram_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(1)) dut_l1 (
      .clk(clk), .rstn(rstn),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_is_cap(p0_is_cap), .p0_we(p0_we),
      .p0_be(p0_be), .p0_wdata(p0_wdata), .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid),
      .p0_rdata(b_p0_rdata),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_is_cap(p1_is_cap), .p1_we(p1_we),
      .p1_be(p1_be), .p1_wdata(p1_wdata), .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid),
      .p1_rdata(b_p1_rdata),
      .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_is_cap(b_mem_is_cap),
      .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
      .mem_rdata(mem_rdata)
   );

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   // Reference model: per instance, how many consecutive cycles p1 has been
   // denied while requesting, plus who owns the response due this cycle.
   int limits[2] = '{4, 1};
   int streak[2];
   bit prev_v[2], prev_own[2], prev_we[2];
   bit last_w0, last_w1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         streak[k] = 0; prev_v[k] = 0; prev_own[k] = 0; prev_we[k] = 0;
      end
   endtask

   // Compare both instances against the model for the current cycle, then
   // advance the model as if the coming clock edge has happened.
   task automatic eval();
      bit w0, w1, rv0, rv1, any;
      logic [DW-1:0] rd0, rd1;
      #1;
      for (int k = 0; k < 2; k++) begin
         w1  = rstn && p1_req && (!p0_req || streak[k] >= limits[k]);
         w0  = rstn && p0_req && !w1;
         any = w0 | w1;
         rv0 = rstn && prev_v[k] && !prev_own[k];
         rv1 = rstn && prev_v[k] &&  prev_own[k];
         rd0 = (rv0 && !prev_we[k]) ? mem_rdata : '0;
         rd1 = (rv1 && !prev_we[k]) ? mem_rdata : '0;
         if (k == 0) begin
            check("p0_gnt", 128'(p0_gnt), 128'(w0));
            check("p1_gnt", 128'(p1_gnt), 128'(w1));
            check("mem_en", 128'(mem_en), 128'(any));
            check("mem_addr", 128'(mem_addr), 128'(w0 ? p0_addr : w1 ? p1_addr : 32'h0));
            check("mem_is_cap", 128'(mem_is_cap), 128'(w0 ? p0_is_cap : w1 ? p1_is_cap : 1'b0));
            check("mem_we", 128'(mem_we), 128'(w0 ? p0_we : w1 ? p1_we : 1'b0));
            check("mem_be", 128'(mem_be), 128'(w0 ? p0_be : w1 ? p1_be : 4'h0));
            check("mem_wdata", 128'(mem_wdata), 128'(w0 ? p0_wdata : w1 ? p1_wdata : '0));
            check("p0_rvalid", 128'(p0_rvalid), 128'(rv0));
            check("p1_rvalid", 128'(p1_rvalid), 128'(rv1));
            check("p0_rdata", 128'(p0_rdata), 128'(rd0));
            check("p1_rdata", 128'(p1_rdata), 128'(rd1));
            last_w0 = w0;
            last_w1 = w1;
         end else begin
            check("l1_p0_gnt", 128'(b_p0_gnt), 128'(w0));
            check("l1_p1_gnt", 128'(b_p1_gnt), 128'(w1));
            check("l1_p0_rvalid", 128'(b_p0_rvalid), 128'(rv0));
            check("l1_p1_rvalid", 128'(b_p1_rvalid), 128'(rv1));
            check("l1_p1_rdata", 128'(b_p1_rdata), 128'(rd1));
         end
         if (!rstn) begin
            streak[k] = 0; prev_v[k] = 0; prev_own[k] = 0; prev_we[k] = 0;
         end else begin
            prev_v[k] = any;
            if (any) begin
               prev_own[k] = w1;
               prev_we[k]  = w1 ? p1_we : p0_we;
            end
            streak[k] = (p1_req && !w1) ? streak[k] + 1 : 0;
         end
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
      p0_req = 1'b0;
      p1_req = 1'b0;
      mem_rdata = {1'($urandom), $urandom, $urandom};
   endtask

   task automatic rand_p0();
      p0_req = 1'b1; p0_addr = $urandom; p0_is_cap = 1'($urandom); p0_we = 1'($urandom);
      p0_be = 4'($urandom); p0_wdata = {1'($urandom), $urandom, $urandom};
   endtask

   task automatic rand_p1();
      p1_req = 1'b1; p1_addr = $urandom; p1_is_cap = 1'($urandom); p1_we = 1'($urandom);
      p1_be = 4'($urandom); p1_wdata = {1'($urandom), $urandom, $urandom};
   endtask

   initial begin
      rstn = 1'b0;
      p0_req = 0; p0_addr = 0; p0_is_cap = 0; p0_we = 0; p0_be = 0; p0_wdata = '0;
      p1_req = 0; p1_addr = 0; p1_is_cap = 0; p1_we = 0; p1_be = 0; p1_wdata = '0;
      mem_rdata = '0;
      model_reset();

      // Reset state, even with both ports requesting.
      p0_req = 1'b1; p1_req = 1'b1;
      eval();
      next_cycle();
      eval();
      next_cycle();
      rstn = 1'b1;
      eval();

      // Single read from port 0.
      next_cycle();
      p0_req = 1'b1; p0_addr = 32'h20; p0_we = 1'b0; p0_is_cap = 1'b0; p0_be = 4'hF;
      eval();
      check("read_addr", 128'(mem_addr), 128'(32'h20));
      next_cycle();
      mem_rdata = 65'h0_DEADBEEF;
      eval();
      check("read_data", 128'(p0_rdata), 128'(65'h0_DEADBEEF));

      // Write completion on port 1.
      next_cycle();
      p1_req = 1'b1; p1_we = 1'b1; p1_be = 4'b0011; p1_wdata = 65'h1234; p1_addr = 32'h40;
      p1_is_cap = 1'b0;
      eval();
      check("write_be", 128'(mem_be), 128'(4'b0011));
      next_cycle();
      eval();

      // Starvation: both ports held high for ten cycles.
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         rand_p0();
         rand_p1();
         eval();
         check("starve_pattern", 128'(p1_gnt), 128'(i == 4 || i == 9));
      end
      next_cycle();
      eval();
      next_cycle();
      eval();

      // Back-to-back owner switch: p0 read then p1 write.
      next_cycle();
      rand_p0(); p0_we = 1'b0;
      eval();
      next_cycle();
      rand_p1(); p1_we = 1'b1;
      eval();
      check("b2b_p0_rvalid", 128'(p0_rvalid), 128'(1'b1));
      check("b2b_p1_gnt", 128'(p1_gnt), 128'(1'b1));
      next_cycle();
      eval();
      check("b2b_p1_rvalid", 128'(p1_rvalid), 128'(1'b1));

      // Capability-width write pass-through.
      next_cycle();
      rand_p0(); p0_is_cap = 1'b1; p0_we = 1'b1;
      p0_wdata = {1'b1, 64'hA5A5_A5A5_A5A5_A5A5};
      eval();
      check("cap_flag", 128'(mem_is_cap), 128'(1'b1));
      check("cap_wdata", 128'(mem_wdata), 128'({1'b1, 64'hA5A5_A5A5_A5A5_A5A5}));

      // Reset the cycle after a p0 read grant.
      next_cycle();
      rand_p0(); p0_we = 1'b0;
      eval();
      next_cycle();
      rstn = 1'b0;
      p0_req = 1'b1;
      eval();
      check("rst_mem_en", 128'(mem_en), 128'(1'b0));
      check("rst_p0_rvalid", 128'(p0_rvalid), 128'(1'b0));
      next_cycle();
      rstn = 1'b1;
      rand_p1();
      eval();
      check("post_rst_p1_gnt", 128'(p1_gnt), 128'(1'b1));

      // Random traffic; each requester holds its request until granted.
      last_w0 = 1'b0;
      last_w1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic h0, h1;
         h0 = p0_req && !last_w0;
         h1 = p1_req && !last_w1;
         @(negedge clk);
         mem_rdata = {1'($urandom), $urandom, $urandom};
         rstn = ($urandom_range(0, 79) != 0);
         if (!h0) begin
            p0_req = 1'b0;
            if ($urandom_range(0, 99) < 60) rand_p0();
         end
         if (!h1) begin
            p1_req = 1'b0;
            if ($urandom_range(0, 99) < 50) rand_p1();
         end
         eval();
      end

      next_cycle();
      rstn = 1'b1;
      eval();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
